// File: rtl/adc_sequencer_pkg.sv
// Shared definitions for the ADC sweep sequencer: register map, FSM states,
// FIFO geometry and the conversion-request timeout.
package adc_sequencer_pkg;

  localparam int REG_CTRL   = 0;
  localparam int REG_MASK   = 1;
  localparam int REG_PERIOD = 2;
  localparam int REG_STATUS = 3;
  localparam int REG_FIFO   = 4;
  localparam int REG_COUNT  = 5;

  localparam int FIFO_DEPTH = 16;
  localparam int FIFO_AW    = 4;

  localparam int TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SCAN,
    ST_REQ,
    ST_STORE
  } state_t;

endpackage

// File: rtl/adc_sequencer_fifo.sv
// sample_fifo: 16-entry sample buffer with occupancy count and synchronous clear.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module sample_fifo
  import adc_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        push,
  input  logic        pop,
  input  logic [15:0] din,
  output logic [15:0] head,
  output logic [4:0]  count,
  output logic        full,
  output logic        empty
);

  logic [15:0]        mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wptr, rptr;
  logic               do_push, do_pop;

  assign full    = (count == 5'(FIFO_DEPTH));
  assign empty   = (count == 5'd0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wptr] <= din;
  end

endmodule

// File: rtl/adc_sequencer.sv
// ADC sweep sequencer: EBI register block, period-driven channel sweep FSM and
// sample FIFO feeding the bus.
//   state    | meaning
//   ST_IDLE  | stopped, waiting for run
//   ST_WAIT  | period counter running until the next sweep
//   ST_SCAN  | pick next masked channel, end or restart the sweep
//   ST_REQ   | conv_req held until conv_ack or timeout
//   ST_STORE | push {chan, sample} into the FIFO
module adc_sequencer
  import adc_sequencer_pkg::*;
#(
  parameter int POSITION = 300,
  parameter int NCHAN    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [18:0] addr,
  input  logic        wr,
  input  logic        re,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        conv_req,
  output logic [2:0]  conv_chan,
  input  logic        conv_ack,
  input  logic [11:0] conv_data
);

  logic [18:0]      off;
  logic             in_block, wr_act, wr_q, wr_pulse, rd_fifo, rd_q, pop;
  logic             run, clr_q, ovf, ovr, tmo_flag;
  logic [NCHAN-1:0] mask;
  logic [15:0]      period, cnt, head;
  state_t           state;
  logic [3:0]       start;
  logic [9:0]       tmo_cnt;
  logic [11:0]      sample;
  logic             pend, period_hit, scan_found, push, full, empty;
  logic             ovf_set, ovr_set, tmo_set, sweep_on;
  logic [2:0]       scan_ch;
  logic [4:0]       count;

  assign off      = addr - 19'(POSITION);
  assign in_block = enable && (addr >= 19'(POSITION)) && (off < 19'(REG_COUNT));
  assign wr_act   = in_block && wr;
  assign wr_pulse = wr_act && !wr_q;
  assign rd_fifo  = in_block && re && (off == 19'(REG_FIFO));
  assign pop      = rd_q && !rd_fifo;

  assign push       = (state == ST_STORE);
  assign period_hit = (period != 16'd0) && (cnt == period - 16'd1);
  // A sweep that is about to finish in SCAN does not count as overrun.
  assign sweep_on   = (state == ST_REQ) || (state == ST_STORE) ||
                      ((state == ST_SCAN) && run && scan_found);
  assign ovr_set    = sweep_on && period_hit;
  assign tmo_set    = (state == ST_REQ) && !conv_ack && (tmo_cnt == 10'd0);
  assign ovf_set    = push && full && !pop && !clr_q;

  always_comb begin
    scan_found = 1'b0;
    scan_ch    = 3'd0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(start))) begin
        scan_found = 1'b1;
        scan_ch    = 3'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      run      <= 1'b0;
      clr_q    <= 1'b0;
      mask     <= '0;
      period   <= '0;
      ovf      <= 1'b0;
      ovr      <= 1'b0;
      tmo_flag <= 1'b0;
    end else begin
      wr_q  <= wr_act;
      rd_q  <= rd_fifo;
      clr_q <= 1'b0;
      if (wr_pulse) begin
        case (off)
          19'(REG_CTRL): begin
            run   <= data_in[0];
            clr_q <= data_in[1];
          end
          19'(REG_MASK):   mask   <= data_in[NCHAN-1:0];
          19'(REG_PERIOD): period <= data_in;
          19'(REG_STATUS): begin
            ovf      <= ovf & ~data_in[5];
            ovr      <= ovr & ~data_in[6];
            tmo_flag <= tmo_flag & ~data_in[7];
          end
          default: ;
        endcase
      end
      if (ovf_set) ovf      <= 1'b1;
      if (ovr_set) ovr      <= 1'b1;
      if (tmo_set) tmo_flag <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      conv_req  <= 1'b0;
      conv_chan <= 3'd0;
      cnt       <= '0;
      tmo_cnt   <= '0;
      start     <= '0;
      pend      <= 1'b0;
      sample    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt  <= '0;
          pend <= 1'b0;
          if (run) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!run) begin
            state <= ST_IDLE;
          end else if ((period == 16'd0) || (cnt == period - 16'd1)) begin
            state <= ST_SCAN;
            cnt   <= '0;
            start <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_SCAN: begin
          cnt <= cnt + 16'd1;
          if (ovr_set) pend <= 1'b1;
          if (!run) begin
            state <= ST_IDLE;
          end else if (scan_found) begin
            conv_req  <= 1'b1;
            conv_chan <= scan_ch;
            start     <= {1'b0, scan_ch} + 4'd1;
            tmo_cnt   <= 10'(TIMEOUT_CYCLES - 1);
            state     <= ST_REQ;
          end else if (pend || period_hit) begin
            // next sweep follows at once, counter restarts with it
            start <= '0;
            cnt   <= '0;
            pend  <= 1'b0;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_REQ: begin
          cnt <= cnt + 16'd1;
          if (ovr_set) pend <= 1'b1;
          if (conv_ack) begin
            conv_req <= 1'b0;
            sample   <= conv_data;
            state    <= ST_STORE;
          end else if (tmo_cnt == 10'd0) begin
            conv_req <= 1'b0;
            state    <= ST_SCAN;
          end else begin
            tmo_cnt <= tmo_cnt - 10'd1;
          end
        end
        ST_STORE: begin
          cnt <= cnt + 16'd1;
          if (ovr_set) pend <= 1'b1;
          state <= ST_SCAN;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sample_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clr_q),
    .push  (push),
    .pop   (pop),
    .din   ({1'b0, conv_chan, sample}),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    data_out = 16'h0000;
    if (in_block && re) begin
      case (off)
        19'(REG_CTRL):   data_out = {15'd0, run};
        19'(REG_MASK):   data_out[NCHAN-1:0] = mask;
        19'(REG_PERIOD): data_out = period;
        19'(REG_STATUS): data_out = {7'd0, state != ST_IDLE, tmo_flag, ovr, ovf, count};
        19'(REG_FIFO):   data_out = empty ? 16'h0000 : head;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_sequencer.sv
// Bench for adc_sequencer: register vector table, directed sweep/FIFO/timeout/reset
// sequences and randomized sweeps checked against a queue-based model.
module tb_adc_sequencer;

  localparam int POS = 300;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [18:0] addr = '0;
  logic        wr = 1'b0;
  logic        re = 1'b0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic        conv_req;
  logic [2:0]  conv_chan;
  logic        conv_ack = 1'b0;
  logic [11:0] conv_data = '0;

  always #5 clk = ~clk;

  adc_sequencer #(.POSITION(POS), .NCHAN(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .addr      (addr),
    .wr        (wr),
    .re        (re),
    .data_in   (data_in),
    .data_out  (data_out),
    .conv_req  (conv_req),
    .conv_chan (conv_chan),
    .conv_ack  (conv_ack),
    .conv_data (conv_data)
  );

  typedef struct {
    int          off;
    bit          do_wr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  bit req_prev = 1'b0;
  int rise_t[$];
  int rise_ch[$];
  int fall_t[$];

  bit          resp_on = 1'b0;
  int          resp_lat = -1;
  logic [15:0] mq[$];
  bit          m_ovf = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (conv_req && !req_prev) begin
        rise_t.push_back(cyc);
        rise_ch.push_back(int'(conv_chan));
      end
      if (!conv_req && req_prev) fall_t.push_back(cyc);
      req_prev = conv_req;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic model_push(logic [15:0] e);
    if (mq.size() < 16) mq.push_back(e);
    else m_ovf = 1'b1;
  endtask

  task automatic responder();
    int          lat;
    logic [2:0]  ch;
    logic [11:0] d;
    forever begin
      @(negedge clk);
      if (resp_on && conv_req) begin
        ch  = conv_chan;
        lat = (resp_lat < 0) ? int'($urandom_range(0, 6)) : resp_lat;
        repeat (lat) @(negedge clk);
        d = 12'($urandom);
        conv_data = d;
        conv_ack  = 1'b1;
        model_push({1'b0, ch, d});
        @(negedge clk);
        conv_ack = 1'b0;
      end
    end
  endtask

  task automatic bus_write(int off, logic [15:0] d);
    @(negedge clk);
    enable  = 1'b1;
    addr    = 19'(POS + off);
    data_in = d;
    wr      = 1'b1;
    repeat (3) @(negedge clk);
    wr     = 1'b0;
    enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_read(int off, output logic [15:0] d);
    @(negedge clk);
    enable = 1'b1;
    addr   = 19'(POS + off);
    re     = 1'b1;
    repeat (3) @(negedge clk);
    d      = data_out;
    re     = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    resp_on = 1'b0;
    conv_ack = 1'b0;
    repeat (3) @(negedge clk);
    mq.delete();
    m_ovf = 1'b0;
    rise_t.delete();
    rise_ch.delete();
    fall_t.delete();
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_rises(int n, int budget, string name);
    int k = 0;
    while (rise_t.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(rise_t.size() >= n), 1);
  endtask

  task automatic man_ack(logic [11:0] d, string name);
    int k = 0;
    while (!conv_req && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(conv_req), 1);
    conv_data = d;
    conv_ack  = 1'b1;
    @(negedge clk);
    conv_ack = 1'b0;
  endtask

  task automatic drain(string tag);
    logic [15:0] s, d;
    int n;
    bus_read(3, s);
    check({tag, "_count"}, 32'(s[4:0]), 32'(mq.size()));
    check({tag, "_ovf"}, 32'(s[5]), 32'(m_ovf));
    n = mq.size();
    for (int i = 0; i < n; i++) begin
      bus_read(4, d);
      check($sformatf("%s_fifo%0d", tag, i), 32'(d), 32'(mq.pop_front()));
    end
    bus_read(4, d);
    check({tag, "_empty_read"}, 32'(d), 0);
  endtask

  initial begin
    logic [15:0] d, s, d_rd;
    logic [11:0] smp;
    vec_t        vt[$];
    int          expch[$];
    int          k;
    logic [7:0]  m;

    fork
      responder();
    join_none

    repeat (3) @(negedge clk);
    check("rst_conv_req", 32'(conv_req), 0);
    check("rst_conv_chan", 32'(conv_chan), 0);
    check("rst_data_out", 32'(data_out), 0);
    reset = 1'b1;
    @(negedge clk);

    // register map vectors
    vt.push_back(vec_t'{0, 1'b0, 16'h0000, 16'h0000});
    vt.push_back(vec_t'{1, 1'b0, 16'h0000, 16'h0000});
    vt.push_back(vec_t'{2, 1'b0, 16'h0000, 16'h0000});
    vt.push_back(vec_t'{3, 1'b0, 16'h0000, 16'h0000});
    vt.push_back(vec_t'{4, 1'b0, 16'h0000, 16'h0000});
    vt.push_back(vec_t'{2, 1'b1, 16'hBEEF, 16'hBEEF});
    vt.push_back(vec_t'{1, 1'b1, 16'h01A5, 16'h00A5});
    vt.push_back(vec_t'{0, 1'b1, 16'h0002, 16'h0000});
    vt.push_back(vec_t'{3, 1'b1, 16'hFFFF, 16'h0000});
    vt.push_back(vec_t'{5, 1'b1, 16'h1234, 16'h0000});
    vt.push_back(vec_t'{-1, 1'b1, 16'h5678, 16'h0000});
    vt.push_back(vec_t'{2, 1'b1, 16'h0000, 16'h0000});
    vt.push_back(vec_t'{1, 1'b1, 16'h0000, 16'h0000});
    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].do_wr) bus_write(vt[i].off, vt[i].wdata);
      bus_read(vt[i].off, d);
      check($sformatf("vec%0d", i), 32'(d), 32'(vt[i].exp));
    end

    // mask 0x05, period 100, ack latency 10
    do_reset();
    resp_on = 1'b1;
    resp_lat = 10;
    bus_write(1, 16'h0005);
    bus_write(2, 16'd100);
    bus_write(0, 16'h0001);
    wait_rises(4, 600, "p37_rises");
    if (rise_t.size() >= 4) begin
      check("p37_ch_a", 32'(rise_ch[0]), 0);
      check("p37_ch_b", 32'(rise_ch[1]), 2);
      check("p37_ch_c", 32'(rise_ch[2]), 0);
      check("p37_ch_d", 32'(rise_ch[3]), 2);
      check("p37_period_a", 32'(rise_t[2] - rise_t[0]), 100);
      check("p37_period_b", 32'(rise_t[3] - rise_t[1]), 100);
    end
    repeat (30) @(negedge clk);
    bus_write(0, 16'h0000);
    resp_on = 1'b0;
    repeat (5) @(negedge clk);
    drain("p37");

    // period shorter than the sweep: overrun and back-to-back sweeps
    do_reset();
    resp_on = 1'b1;
    resp_lat = 20;
    bus_write(1, 16'h00FF);
    bus_write(2, 16'd10);
    bus_write(0, 16'h0001);
    wait_rises(10, 1000, "p38_rises");
    bus_read(3, s);
    check("p38_overrun", 32'(s[6]), 1);
    if (rise_t.size() >= 10) begin
      check("p38_wrap_ch", 32'(rise_ch[8]), 0);
      check("p38_back_to_back", 32'((rise_t[8] - rise_t[7]) < 30), 1);
    end
    bus_write(0, 16'h0000);
    repeat (40) @(negedge clk);
    resp_on = 1'b0;

    // mask 0: no requests but the sequencer stays busy
    do_reset();
    bus_write(2, 16'd5);
    bus_write(0, 16'h0001);
    repeat (200) @(negedge clk);
    check("p23_no_req", 32'(rise_t.size()), 0);
    bus_read(3, s);
    check("p23_busy", 32'(s[8]), 1);
    bus_write(0, 16'h0000);
    repeat (3) @(negedge clk);
    bus_read(3, s);
    check("p23_idle", 32'(s[8]), 0);

    // FIFO fill, overflow, aligned push+pop, then reset during REQ
    do_reset();
    bus_write(1, 16'h0001);
    bus_write(2, 16'd0);
    bus_write(0, 16'h0001);
    for (int i = 0; i < 16; i++) begin
      smp = 12'($urandom);
      man_ack(smp, "fill_req");
      model_push({4'h0, smp});
    end
    repeat (3) @(negedge clk);
    bus_read(3, s);
    check("fill_count16", 32'(s[4:0]), 16);
    check("fill_ovf0", 32'(s[5]), 0);
    smp = 12'($urandom);
    man_ack(smp, "ovf_req");
    model_push({4'h0, smp});
    repeat (3) @(negedge clk);
    bus_read(3, s);
    check("ovf_count", 32'(s[4:0]), 16);
    check("ovf_flag", 32'(s[5]), 32'(m_ovf));
    bus_read(4, d);
    check("ovf_head", 32'(d), 32'(mq.pop_front()));
    bus_write(3, 16'h0020);
    m_ovf = 1'b0;
    bus_read(3, s);
    check("ovf_cleared", 32'(s[5]), 0);
    check("ovf_count15", 32'(s[4:0]), 15);
    smp = 12'($urandom);
    man_ack(smp, "refill_req");
    model_push({4'h0, smp});
    k = 0;
    while (!conv_req && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("align_req", 32'(conv_req), 1);
    enable = 1'b1;
    addr = 19'(POS + 4);
    re = 1'b1;
    repeat (2) @(negedge clk);
    smp = 12'($urandom);
    conv_data = smp;
    conv_ack = 1'b1;
    @(negedge clk);
    d_rd = data_out;
    conv_ack = 1'b0;
    re = 1'b0;
    enable = 1'b0;
    check("align_pop_val", 32'(d_rd), 32'(mq.pop_front()));
    model_push({4'h0, smp});
    repeat (3) @(negedge clk);
    bus_read(3, s);
    check("align_count", 32'(s[4:0]), 16);
    check("align_ovf", 32'(s[5]), 0);
    bus_read(4, d);
    check("align_next_head", 32'(d), 32'(mq.pop_front()));
    k = 0;
    while (!conv_req && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("p42_req_high", 32'(conv_req), 1);
    #2 reset = 1'b0;
    #1 check("p42_async_drop", 32'(conv_req), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mq.delete();
    m_ovf = 1'b0;
    conv_ack = 1'b1;
    @(negedge clk);
    conv_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("p42_late_ack", 32'(conv_req), 0);
    for (int i = 0; i < 5; i++) begin
      bus_read(i, d);
      check($sformatf("p42_reg%0d", i), 32'(d), 0);
    end

    // request timeout on channel 3
    do_reset();
    bus_write(1, 16'h0008);
    bus_write(2, 16'd1500);
    bus_write(0, 16'h0001);
    wait_rises(1, 1600, "p40_rise");
    k = 0;
    while (fall_t.size() < 1 && k < 1200) begin
      @(negedge clk);
      k++;
    end
    check("p40_fall", 32'(fall_t.size() >= 1), 1);
    if (rise_t.size() >= 1 && fall_t.size() >= 1) begin
      check("p40_chan", 32'(rise_ch[0]), 3);
      check("p40_len", 32'(fall_t[0] - rise_t[0]), 1024);
    end
    bus_read(3, s);
    check("p40_timeout", 32'(s[7]), 1);
    check("p40_fifo_empty", 32'(s[4:0]), 0);
    bus_write(3, 16'h0080);
    bus_read(3, s);
    check("p40_timeout_clr", 32'(s[7]), 0);
    bus_write(0, 16'h0000);

    // randomized single sweeps against the mask/queue model
    for (int t = 0; t < 4; t++) begin
      do_reset();
      m = 8'($urandom_range(0, 255));
      expch.delete();
      for (int c = 0; c < 8; c++) if (m[c]) expch.push_back(c);
      resp_on = 1'b1;
      resp_lat = -1;
      bus_write(1, {8'h00, m});
      bus_write(2, 16'd200);
      bus_write(0, 16'h0001);
      wait_rises(expch.size(), 500, $sformatf("rnd%0d_rises", t));
      repeat (20) @(negedge clk);
      bus_write(0, 16'h0000);
      resp_on = 1'b0;
      repeat (5) @(negedge clk);
      check($sformatf("rnd%0d_nreq", t), 32'(rise_ch.size()), 32'(expch.size()));
      for (int i = 0; i < expch.size() && i < rise_ch.size(); i++)
        check($sformatf("rnd%0d_ch%0d", t, i), 32'(rise_ch[i]), 32'(expch[i]));
      drain($sformatf("rnd%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_sequencer.md
ADC_SEQUENCER -- requirements
Module: adc_sequencer

Interface
REQ-001 Parameter POSITION, default 300: base EBI word address of the register block.
REQ-002 Parameter NCHAN, default 8: number of ADC channels in the sweep mask (1..8).
REQ-003 clk  in  1  system clock (sys_clk domain); this is the only clock.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 enable  in  1  EBI chip select, already inverted to active-high.
REQ-006 addr  in  19  EBI word address.
REQ-007 wr  in  1  write strobe, active-high, held for several clk cycles per access.
REQ-008 re  in  1  read strobe, active-high, held for several clk cycles per access.
REQ-009 data_in  in  16  EBI write data.
REQ-010 data_out  out  16  read data; drives 16'h0000 whenever the block is not addressed with re high, so it is safe on the wired-OR bus.
REQ-011 conv_req  out  1  conversion request to the ADC core.
REQ-012 conv_chan  out  3  channel for the current request.
REQ-013 conv_ack  in  1  one-cycle pulse; conv_data is valid in that cycle.
REQ-014 conv_data  in  12  conversion result.

Function
REQ-015 Registers at POSITION+n:
- n=0 CTRL (R/W): bit0 run, bit1 fifo_clear; bit1 is self-clearing and reads 0.
- n=1 MASK (R/W): bits[NCHAN-1:0] select the channels in a sweep.
- n=2 PERIOD (R/W): 16-bit sweep period in clk cycles.
- n=3 STATUS (RO): [4:0] fifo_count, [5] overflow, [6] overrun, [7] timeout, [8] busy.
- n=4 FIFO (RO): head entry {1'b0, chan[2:0], sample[11:0]}.
REQ-016 A write takes effect once per strobe, on the first cycle of enable&wr&address-hit (rising-edge detect).
REQ-017 A STATUS write clears the sticky bits [7:5] where data_in has a 1.
REQ-018 Read data is combinational from the current register and FIFO head state while the strobe is active.
REQ-019 A FIFO read pops one entry on the cycle after the read strobe deasserts (falling-edge detect); data_out stays stable for the whole strobe.
REQ-020 FSM states:
- IDLE: waits for run=1, then goes to WAIT.
- WAIT: a 16-bit period counter runs; at count==PERIOD-1, or immediately if PERIOD=0, go to SCAN.
- SCAN: select the lowest mask bit above the last channel serviced in this sweep; if none remains, return to WAIT (or IDLE if run=0).
- REQ: hold conv_req=1 with conv_chan stable until conv_ack.
- STORE: one cycle; push the entry, then go to SCAN.
REQ-021 The period counter restarts at the start of each sweep, not at its end.
REQ-022 If the period expires while a sweep is in progress, set overrun; the next sweep starts directly after the current one, with no WAIT.
REQ-023 MASK=0: SCAN returns to WAIT immediately and no request is ever issued.
REQ-024 A MASK or PERIOD write mid-sweep takes effect at the next SCAN decision and the next counter compare, respectively.
REQ-025 run cleared mid-sweep: any outstanding REQ completes and its sample is stored, then the FSM goes to IDLE.
REQ-026 Timeout: if REQ lasts 1024 cycles without conv_ack, drop conv_req, set timeout, skip that channel, and go to SCAN.
REQ-027 FIFO depth is 16.
REQ-028 Push while full: drop the sample, set overflow, leave contents unchanged.
REQ-029 Pop while empty: no effect; data_out reads 16'h0000.
REQ-030 Simultaneous push and pop: both happen and the count is unchanged (this also applies when full).
REQ-031 fifo_clear empties the FIFO on the cycle after the write; a push in that same cycle is discarded.
REQ-032 busy=1 in every state except IDLE.

Reset
REQ-033 While reset=0: conv_req=0, conv_chan=0, data_out=0, FSM=IDLE, CTRL=0, MASK=0, PERIOD=0, counters=0, FIFO empty, sticky flags 0, edge-detect registers 0.
REQ-034 Reset asserted mid-REQ drops conv_req at once (asynchronously), and a late conv_ack after release is ignored because the FSM is in IDLE.

Structure
REQ-035 A shared package holds the register offsets, the FSM state enumeration, the FIFO depth and the timeout constant.
REQ-036 The FIFO is one sub-module, sample_fifo (16x16, count output, synchronous clear).

Verification
REQ-037 MASK=0x05, PERIOD=100, run=1, ack 10 cycles after each request -> requests on channels 0 then 2, repeating every 100 cycles; FIFO holds 0x0xxx and 0x2xxx alternately.
REQ-038 PERIOD=10, MASK=0xFF, ack latency 20 -> overrun=1 and sweeps run back-to-back.
REQ-039 Fill the FIFO to 16 without reads, then one more ack -> count=16, overflow=1, head entry unchanged.
REQ-040 conv_ack never asserted on channel 3 (MASK=0x08) -> conv_req drops after 1024 cycles and timeout=1; a STATUS write of 0x80 clears it.
REQ-041 Read strobe on FIFO aligned with a STORE cycle at count=16 -> count stays 16, overflow=0, popped value equals the prior head.
REQ-042 Reset pulse while conv_req=1 -> conv_req=0 immediately and all registers read 0 after release.
